systolic_seq_ctrl: RTL and testbench
====================================

// Module: systolic_seq_ctrl
// PURPOSE
//  Sequencer for the ROWS x COLS output-stationary int8 MAC array (27-bit accumulators).
//  - Accepts a job of depth k_len and reads operand columns from the A/B buffers.
//  - Skews and zero-masks the operands onto the array edge lanes, then drives pe_en and array_clr.
//  - Drains accumulated rows to the writeback stage over a valid/ready handshake.
// PARAMETERS
//  ROWS    4   array rows (A lanes)
//  COLS    4   array columns (B lanes)
//  K_W     10  width of k_len; max depth 2**K_W-1
//  ACC_W   27  accumulator width per PE
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           asynchronous, active-high reset
//  start      in   1           job request; sampled only in IDLE
//  k_len      in   K_W         inner-product depth; sampled with start
//  busy       out  1           high in every state except IDLE
//  done       out  1           one-cycle pulse at job end
//  rd_en      out  1           A/B buffer read strobe; buffer read latency is 1 cycle
//  rd_addr    out  K_W         A/B buffer column address
//  a_in       in   ROWS*8      A column from buffer, signed int8 lanes
//  b_in       in   COLS*8      B row from buffer, signed int8 lanes
//  a_lane     out  ROWS*8      skewed, masked A edge lanes
//  b_lane     out  COLS*8      skewed, masked B edge lanes
//  pe_en      out  1           array accumulate enable
//  array_clr  out  1           one-cycle accumulator clear; top maps it onto the PE reset net
//  row_sel    out  $clog2(ROWS) row index being drained
//  out_valid  out  1           drain data valid
//  out_ready  in   1           writeback accepts the row
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and skew registers are 0. A reset mid-job aborts immediately with no done pulse.
//  FSM: IDLE -> CLEAR -> FEED -> SETTLE -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches k_len and goes to CLEAR. start in any other state is ignored.
//  CLEAR: 1 cycle, array_clr=1, pe_en=0. k_len==0 goes straight to SETTLE, so all rows drain as zeros.
//  FEED: counter f=0..F-1, with F = k_len+ROWS+COLS-1 (covers the farthest PE hop).
//   - rd_en = (f<k_len); rd_addr = f while rd_en=1, else holds 0.
//   - a_lane[i] = a[i][f-1-i] when 0 <= f-1-i < k_len, else 8'sd0. b_lane[j] follows the same rule with j.
//   - Lane 0 is the masked buffer output (no register). Lane n passes through n skew registers.
//   - pe_en = 1 for f>=1. Zero-masked lanes make the extra MACs harmless.
//  SETTLE: 1 cycle, pe_en=0, lanes=0; lets the final accumulate land.
//  DRAIN: row_sel = 0..ROWS-1, out_valid=1.
//   - Advance when out_valid & out_ready; the last accept goes to DONE.
//   - While stalled, row_sel holds.
//  DONE: done=1 for 1 cycle; busy=0 from the next cycle. start in DONE is ignored.
//  Counters are sized for F_max = 2**K_W-1+ROWS+COLS-1; no wrap-around is possible within a job.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined:
//   - Adds output perf_cycles[31:0]: counts busy cycles of the current job, cleared on entering CLEAR.
//   - Adds output perf_stalls[31:0]: counts DRAIN cycles with out_ready=0.
//   - Both counters saturate at all-ones and hold their values after DONE.
//  SEQ_PERF_CNT_EN undefined: neither port nor any counter logic exists.
// STRUCTURE
//  Package systolic_pkg:
//   - state encoding: IDLE, CLEAR, FEED, SETTLE, DRAIN, DONE
//   - LANE_W=8 and ACC_W=27
//   - function feed_len(k,rows,cols)
//  Sub-module systolic_skew_lane, instantiated once for A and once for B:
//   - parameters N (lanes) and K_W
//   - triangular delay registers plus per-lane window mask from f and k_len
// TESTING
//  1. reset high mid-FEED (k_len=8) -> next edge: IDLE, busy=0, pe_en=0, all lanes 0, no done.
//  2. start, k_len=1, ROWS=COLS=4 -> array_clr at cycle 1.
//     - FEED lasts 8 cycles; a_lane[3] is nonzero only at f=4.
//     - out_valid rows 0..3; done 1 cycle after the 4th accept.
//  3. k_len=5, lane0 buffer data = 1..5 -> a_lane[0] = 1,2,3,4,5 at f=1..5 and 0 elsewhere.
//     - a_lane[2] shows the same sequence at f=3..7.
//  4. k_len=0 -> CLEAR, SETTLE, then 4 drain rows with zero reads (rd_en never 1), then done.
//  5. out_ready held low 3 cycles on row 1 -> row_sel stays 1 and out_valid stays 1.
//     - With SEQ_PERF_CNT_EN: perf_stalls = 3.
//  6. start pulsed during FEED and during DONE -> ignored; job and done count unchanged.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
//   seq_state_e : sequencer FSM states
//   LANE_W      : operand lane width (signed int8)
//   ACC_W       : per-PE accumulator width
//   feed_len()  : number of FEED cycles for a job of depth k
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        SETTLE,
        DRAIN,
        DONE
    } seq_state_e;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned ACC_W  = 27;

    // Operands need k cycles plus the hop to the farthest PE.
    function automatic int unsigned feed_len(input int unsigned k,
                                             input int unsigned rows,
                                             input int unsigned cols);
        return k + rows + cols - 1;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// Skews one edge of the array: lane n is delayed by n cycles through a
// triangular register chain, then zero-masked outside its data window.
//   clk, reset   : clock, asynchronous active-high reset
//   shift_en_i   : advance the delay chains (FEED only)
//   active_i     : lanes may carry data (FEED only); otherwise all lanes 0
//   f_i          : FEED cycle counter
//   k_len_i      : job depth
//   data_i       : buffer output, N packed int8 lanes
//   lane_o       : skewed, masked edge lanes
module systolic_skew_lane
    import systolic_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned K_W   = 10,
    parameter int unsigned CNT_W = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_en_i,
    input  logic                  active_i,
    input  logic [CNT_W-1:0]      f_i,
    input  logic [K_W-1:0]        k_len_i,
    input  logic [N*LANE_W-1:0]   data_i,
    output logic [N*LANE_W-1:0]   lane_o
);

    for (genvar g = 0; g < N; g++) begin : g_lane
        localparam int unsigned DEPTH = g;
        logic [LANE_W-1:0] tap;
        logic              win;

        if (DEPTH == 0) begin : g_direct
            always_comb tap = data_i[0 +: LANE_W];
        end else begin : g_dly
            logic [LANE_W-1:0] dly_q [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned k = 0; k < DEPTH; k++) dly_q[k] <= '0;
                end else if (shift_en_i) begin
                    dly_q[0] <= data_i[DEPTH*LANE_W +: LANE_W];
                    for (int unsigned k = 1; k < DEPTH; k++) dly_q[k] <= dly_q[k-1];
                end
            end

            always_comb tap = dly_q[DEPTH-1];
        end

        // Column index at this lane is f-1-g; valid while 0 <= f-1-g < k_len.
        always_comb begin
            win = active_i
                  && (32'(f_i) >= DEPTH + 1)
                  && (32'(f_i) <  32'(k_len_i) + DEPTH + 1);
            lane_o[DEPTH*LANE_W +: LANE_W] = win ? tap : '0;
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a ROWS x COLS output-stationary int8 MAC array.
// Runs a job: clear accumulators, feed skewed operand columns from the A/B
// buffers, settle, drain each row over valid/ready, then pulse done.
//   clk, reset          : clock, asynchronous active-high reset
//   start, k_len        : job request and depth (sampled in IDLE only)
//   busy, done          : job activity and one-cycle completion pulse
//   rd_en, rd_addr      : A/B buffer read port (1-cycle read latency)
//   a_in, b_in          : buffer data, packed int8 lanes
//   a_lane, b_lane      : skewed, masked array edge lanes
//   pe_en, array_clr    : array accumulate enable and accumulator clear
//   row_sel, out_valid,
//   out_ready           : row drain handshake
// Build option SEQ_PERF_CNT_EN adds perf_cycles / perf_stalls counters.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned K_W   = 10,
    parameter int unsigned ACC_W = 27
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [K_W-1:0]            k_len,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [K_W-1:0]            rd_addr,
    input  logic [ROWS*LANE_W-1:0]    a_in,
    input  logic [COLS*LANE_W-1:0]    b_in,
    output logic [ROWS*LANE_W-1:0]    a_lane,
    output logic [COLS*LANE_W-1:0]    b_lane,
    output logic                      pe_en,
    output logic                      array_clr,
    output logic [$clog2(ROWS)-1:0]   row_sel,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]               perf_cycles,
    output logic [31:0]               perf_stalls
`endif
);

    // Wide enough for the longest feed: 2**K_W-1 + ROWS + COLS - 1 cycles.
    localparam int unsigned CNT_W = $clog2((1 << K_W) + ROWS + COLS - 1);
    localparam int unsigned ROW_W = $clog2(ROWS);

    if (ACC_W != systolic_pkg::ACC_W) begin : g_acc_w_check
        $error("ACC_W must match the array accumulator width");
    end

    seq_state_e       state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] f_q, f_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             feeding;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            f_q     <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            f_q     <= f_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        f_d       = f_q;
        row_d     = row_q;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        pe_en     = 1'b0;
        array_clr = 1'b0;
        row_sel   = '0;
        out_valid = 1'b0;
        feeding   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    k_d     = k_len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                array_clr = 1'b1;
                f_d       = '0;
                row_d     = '0;
                state_d   = (k_q == '0) ? SETTLE : FEED;
            end
            FEED: begin
                feeding = 1'b1;
                rd_en   = (32'(f_q) < 32'(k_q));
                rd_addr = rd_en ? f_q[K_W-1:0] : '0;
                pe_en   = (f_q != '0);
                if (32'(f_q) == feed_len(32'(k_q), ROWS, COLS) - 1) begin
                    state_d = SETTLE;
                end else begin
                    f_d = f_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                row_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                row_sel   = row_q;
                if (out_ready) begin
                    if (row_q == ROW_W'(ROWS - 1)) state_d = DONE;
                    else                           row_d   = row_q + ROW_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    systolic_skew_lane #(.N(ROWS), .K_W(K_W), .CNT_W(CNT_W)) u_skew_a (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (feeding),
        .active_i   (feeding),
        .f_i        (f_q),
        .k_len_i    (k_q),
        .data_i     (a_in),
        .lane_o     (a_lane)
    );

    systolic_skew_lane #(.N(COLS), .K_W(K_W), .CNT_W(CNT_W)) u_skew_b (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (feeding),
        .active_i   (feeding),
        .f_i        (f_q),
        .k_len_i    (k_q),
        .data_i     (b_in),
        .lane_o     (b_lane)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stalls_q;

    // Cleared when a job is accepted; idle cycles do not count, so the
    // values of the last job hold after DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (state_q == IDLE && start) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (state_q != IDLE && perf_cycles_q != '1)
                perf_cycles_q <= perf_cycles_q + 32'd1;
            if (state_q == DRAIN && !out_ready && perf_stalls_q != '1)
                perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    always_comb begin
        perf_cycles = perf_cycles_q;
        perf_stalls = perf_stalls_q;
    end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: per-cycle expected outputs of
// each job are queued when the job is launched and compared every cycle.
module tb_systolic_seq_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int K_W  = 10;

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic [9:0]  k_len;
    logic        busy, done, rd_en, pe_en, array_clr, out_valid;
    logic [9:0]  rd_addr;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] a_lane, b_lane;
    logic [1:0]  row_sel;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .ACC_W(27)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .a_in      (a_in),
        .b_in      (b_in),
        .a_lane    (a_lane),
        .b_lane    (b_lane),
        .pe_en     (pe_en),
        .array_clr (array_clr),
        .row_sel   (row_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls)
`endif
    );

    // A/B buffer model with one cycle read latency.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    always @(posedge clk) begin
        if (rd_en) begin
            a_in <= mem_a[rd_addr[5:0]];
            b_in <= mem_b[rd_addr[5:0]];
        end
    end

    logic [17:0] ctl_now;
    assign ctl_now = {busy, done, rd_en, rd_addr, pe_en, array_clr, row_sel, out_valid};

    typedef struct {
        logic [17:0] ctl;
        logic [31:0] al;
        logic [31:0] bl;
        logic        rdy;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_seen = 0;
    int   exp_busy = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] mk_ctl(input bit bsy, input bit dn, input bit rd,
                                           input int addr, input bit pe, input bit clr,
                                           input int row, input bit ov);
        logic [9:0] a10;
        logic [1:0] r2;
        a10 = 10'(addr);
        r2  = 2'(row);
        return {bsy, dn, rd, a10, pe, clr, r2, ov};
    endfunction

    function automatic logic [31:0] exp_lanes(input bit is_a, input int f, input int k);
        logic [31:0] v, w;
        int idx;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            idx = f - 1 - i;
            if (idx >= 0 && idx < k) begin
                w = is_a ? mem_a[idx] : mem_b[idx];
                v[i*8 +: 8] = w[i*8 +: 8];
            end
        end
        return v;
    endfunction

    // mode 0: random nonzero bytes; mode 1: every A byte of column c is c+1.
    task automatic fill(input int mode);
        logic [31:0] wa, wb;
        for (int c = 0; c < 64; c++) begin
            for (int i = 0; i < 4; i++) begin
                wa[i*8 +: 8] = (mode == 1) ? 8'(c + 1) : 8'($urandom_range(1, 255));
                wb[i*8 +: 8] = 8'($urandom_range(1, 255));
            end
            mem_a[c] = wa;
            mem_b[c] = wb;
        end
    endtask

    task automatic push(input logic [17:0] c, input logic [31:0] al, input logic [31:0] bl, input bit rdy);
        exp_t e;
        e.ctl = c; e.al = al; e.bl = bl; e.rdy = rdy;
        sbq.push_back(e);
        if (c[17]) exp_busy++;
    endtask

    task automatic push_job(input int k, input int stall_row, input int stall_n);
        int nf;
        exp_busy = 0;
        push(mk_ctl(1, 0, 0, 0, 0, 1, 0, 0), '0, '0, 1'b1);           // CLEAR
        if (k > 0) begin
            nf = k + ROWS + COLS - 1;
            for (int f = 0; f < nf; f++)
                push(mk_ctl(1, 0, f < k, (f < k) ? f : 0, f >= 1, 0, 0, 0),
                     exp_lanes(1'b1, f, k), exp_lanes(1'b0, f, k), 1'b1);
        end
        push(mk_ctl(1, 0, 0, 0, 0, 0, 0, 0), '0, '0, 1'b1);           // SETTLE
        for (int r = 0; r < ROWS; r++) begin
            if (r == stall_row)
                for (int s = 0; s < stall_n; s++)
                    push(mk_ctl(1, 0, 0, 0, 0, 0, r, 1), '0, '0, 1'b0);
            push(mk_ctl(1, 0, 0, 0, 0, 0, r, 1), '0, '0, 1'b1);
        end
        push(mk_ctl(1, 1, 0, 0, 0, 0, 0, 0), '0, '0, 1'b1);           // DONE
        push(mk_ctl(0, 0, 0, 0, 0, 0, 0, 0), '0, '0, 1'b1);           // IDLE
        push(mk_ctl(0, 0, 0, 0, 0, 0, 0, 0), '0, '0, 1'b1);
    endtask

    task automatic run_job(input int k, input int stall_row, input int stall_n,
                           input int abort_at, input bit pokes);
        exp_t e;
        int n;
        push_job(k, stall_row, stall_n);
        n = sbq.size();
        start = 1'b1;
        k_len = 10'(k);
        @(negedge clk);
        start = 1'b0;
        k_len = 10'($urandom_range(0, 1023));   // latched value must be used
        for (int idx = 0; idx < n; idx++) begin
            e = sbq.pop_front();
            out_ready = e.rdy;
            start = 1'b0;
            if (idx == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check_eq("abort_ctl", 64'(ctl_now), 64'd0);
                check_eq("abort_alane", 64'(a_lane), 64'd0);
                check_eq("abort_blane", 64'(b_lane), 64'd0);
                reset = 1'b0;
                sbq.delete();
                break;
            end
            check_eq($sformatf("ctl[k=%0d,c=%0d]", k, idx), 64'(ctl_now), 64'(e.ctl));
            check_eq($sformatf("alane[k=%0d,c=%0d]", k, idx), 64'(a_lane), 64'(e.al));
            check_eq($sformatf("blane[k=%0d,c=%0d]", k, idx), 64'(b_lane), 64'(e.bl));
            if (done) done_seen++;
            if (pokes && (idx == 3 || idx == n - 3)) begin
                start = 1'b1;
                k_len = 10'd2;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        k_len = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_ctl", 64'(ctl_now), 64'd0);
        check_eq("reset_lanes", 64'({a_lane, b_lane}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        fill(0);
        run_job(8, -1, 0, 4, 1'b0);          // reset during FEED
        check_eq("abort_no_done", 64'(done_seen), 64'd0);

        fill(0);
        run_job(1, -1, 0, -1, 1'b0);         // minimal depth
        fill(1);
        run_job(5, -1, 0, -1, 1'b0);         // lane data 1..5
        run_job(0, -1, 0, -1, 1'b0);         // empty job
        fill(0);
        run_job(3, 1, 3, -1, 1'b0);          // drain stall on row 1
`ifdef SEQ_PERF_CNT_EN
        check_eq("perf_stalls", 64'(perf_stalls), 64'd3);
        check_eq("perf_cycles", 64'(perf_cycles), 64'(exp_busy));
`endif
        fill(0);
        run_job(4, -1, 0, -1, 1'b1);         // start pokes in FEED and DONE
        fill(0);
        run_job(20, 3, 2, -1, 1'b0);
        check_eq("done_count", 64'(done_seen), 64'd6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
